// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access. Grants one
// requester at a time, formats store lanes, aligns and extends load data.
module mem_arbiter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_addr,
  output logic            or_inst_ack,
  output logic [XLEN-1:0] or_inst_data,

  input  logic            i_data_req,
  input  logic [XLEN-1:0] i_data_addr,
  input  logic            i_data_we,
  input  logic [2:0]      i_data_funct3,
  input  logic [XLEN-1:0] i_data_wdata,
  output logic            or_data_ack,
  output logic [XLEN-1:0] or_data_rdata,
  output logic            or_data_err,

  output logic            or_mem_req,
  output logic [XLEN-1:0] or_mem_addr,
  output logic            or_mem_we,
  output logic [3:0]      or_mem_wstrb,
  output logic [XLEN-1:0] or_mem_wdata,
  input  logic            i_mem_ready,
  input  logic [XLEN-1:0] i_mem_rdata,

  output logic            or_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    ACK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_data_q;   // previous grant went to the data side
  logic            side_data_q;   // transaction in flight belongs to data side
  logic [XLEN-1:0] addr_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic grant_inst;
  logic grant_data;
  logic data_misaligned;
  logic mem_active;

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers 011/110/111 as word).
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lane_wdata(input logic [2:0] f3, input logic [XLEN-1:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // funct3[2] selects zero-extension (BU/HU).
  function automatic logic [XLEN-1:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = 16'(w >> {a[1], 4'b0000});
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Under contention data wins unless it won last time, so the two alternate.
  assign grant_inst      = i_inst_req && (!i_data_req || last_data_q);
  assign grant_data      = i_data_req && !grant_inst;
  assign data_misaligned = misaligned(i_data_funct3, i_data_addr[1:0]);

  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise a missed branch infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_inst)      state_d = INST;
        else if (grant_data) state_d = data_misaligned ? ACK : DATA;
      end
      INST, DATA: if (i_mem_ready) state_d = ACK;
      ACK:        state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and resets asynchronously, so an
  // in-flight memory request is dropped the moment i_rst rises.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b0;
      side_data_q <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      wdata_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_inst) begin
            last_data_q <= 1'b0;
            side_data_q <= 1'b0;
            addr_q      <= i_inst_addr;
            we_q        <= 1'b0;
            funct3_q    <= 3'b010;
            rdata_q     <= '0;
            err_q       <= 1'b0;
          end else if (grant_data) begin
            last_data_q <= 1'b1;
            side_data_q <= 1'b1;
            addr_q      <= i_data_addr;
            we_q        <= i_data_we;
            funct3_q    <= i_data_funct3;
            wdata_q     <= i_data_wdata;
            rdata_q     <= '0;
            err_q       <= data_misaligned;
          end
        end
        INST, DATA: if (i_mem_ready) rdata_q <= i_mem_rdata;
        default: ;
      endcase
    end
  end

  assign mem_active    = (state_q == INST) || (state_q == DATA);

  assign or_mem_req    = mem_active;
  assign or_mem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign or_mem_we     = mem_active && we_q;
  assign or_mem_wstrb  = (mem_active && we_q) ? lane_strb(funct3_q, addr_q[1:0]) : 4'b0000;
  assign or_mem_wdata  = lane_wdata(funct3_q, wdata_q);

  assign or_inst_ack   = (state_q == ACK) && !side_data_q;
  assign or_inst_data  = rdata_q;

  assign or_data_ack   = (state_q == ACK) && side_data_q;
  assign or_data_err   = or_data_ack && err_q;
  assign or_data_rdata = err_q ? '0 : load_align(funct3_q, addr_q[1:0], rdata_q);

  assign or_busy       = state_q != IDLE;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases, contention, reset, and
// randomized transactions against a behavioural model of the load/store rules.
module tb_mem_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        or_inst_ack;
  logic [31:0] or_inst_data;
  logic        i_data_req;
  logic [31:0] i_data_addr;
  logic        i_data_we;
  logic [2:0]  i_data_funct3;
  logic [31:0] i_data_wdata;
  logic        or_data_ack;
  logic [31:0] or_data_rdata;
  logic        or_data_err;
  logic        or_mem_req;
  logic [31:0] or_mem_addr;
  logic        or_mem_we;
  logic [3:0]  or_mem_wstrb;
  logic [31:0] or_mem_wdata;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;
  logic        or_busy;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.XLEN(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .or_inst_ack(or_inst_ack), .or_inst_data(or_inst_data),
    .i_data_req(i_data_req), .i_data_addr(i_data_addr), .i_data_we(i_data_we),
    .i_data_funct3(i_data_funct3), .i_data_wdata(i_data_wdata),
    .or_data_ack(or_data_ack), .or_data_rdata(or_data_rdata), .or_data_err(or_data_err),
    .or_mem_req(or_mem_req), .or_mem_addr(or_mem_addr), .or_mem_we(or_mem_we),
    .or_mem_wstrb(or_mem_wstrb), .or_mem_wdata(or_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .or_busy(or_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---- reference model: RV32I access rules in plain arithmetic ----
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (size_of(f3) == 2 && a % 2 != 0) || (size_of(f3) == 4 && a % 4 != 0);
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    if (size_of(f3) == 1) return 4'(1 << off);
    if (size_of(f3) == 2) return 4'(3 << (off / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (size_of(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (size_of(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    if (size_of(f3) == 1) begin
      v = (w >> (off * 8)) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v - 32'h100;
    end else if (size_of(f3) == 2) begin
      v = (w >> (off / 2 * 16)) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    i_rst = 1'b1;
    i_inst_req = 0; i_inst_addr = 0;
    i_data_req = 0; i_data_addr = 0; i_data_we = 0; i_data_funct3 = 0; i_data_wdata = 0;
    i_mem_ready = 0; i_mem_rdata = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic run_data(input string tag, input logic [31:0] addr, input logic we,
                          input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, output logic [31:0] obs);
    i_data_req = 1; i_data_addr = addr; i_data_we = we; i_data_funct3 = f3; i_data_wdata = wd;
    @(posedge i_clk); #1;
    if (is_misaligned(f3, addr)) begin
      check({tag, ".mis_mem_req"}, 32'(or_mem_req), 0);
      check({tag, ".mis_ack"},     32'(or_data_ack), 1);
      check({tag, ".mis_err"},     32'(or_data_err), 1);
      check({tag, ".mis_rdata"},   or_data_rdata, 0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        i_mem_ready = (k == waits);
        i_mem_rdata = (k == waits) ? rd : $urandom;
        check({tag, ".mem_req"},  32'(or_mem_req), 1);
        check({tag, ".mem_addr"}, or_mem_addr, addr & ~32'h3);
        check({tag, ".mem_we"},   32'(or_mem_we), 32'(we));
        check({tag, ".wstrb"},    32'(or_mem_wstrb), we ? 32'(exp_strb(f3, addr)) : 0);
        if (we) check({tag, ".wdata"}, or_mem_wdata, exp_wdata(f3, wd));
        check({tag, ".early_ack"}, 32'(or_data_ack), 0);
        @(posedge i_clk); #1;
      end
      i_mem_ready = 0;
      check({tag, ".ack"}, 32'(or_data_ack), 1);
      check({tag, ".err"}, 32'(or_data_err), 0);
      if (!we) check({tag, ".rdata"}, or_data_rdata, exp_load(f3, addr, rd));
    end
    check({tag, ".inst_ack"}, 32'(or_inst_ack), 0);
    obs = or_data_rdata;
    i_data_req = 0;
    @(posedge i_clk); #1;
    check({tag, ".ack_pulse"}, 32'(or_data_ack), 0);
    check({tag, ".idle"},      32'(or_busy), 0);
  endtask

  task automatic run_inst(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                          input int waits);
    i_inst_req = 1; i_inst_addr = addr;
    @(posedge i_clk); #1;
    for (int k = 0; k <= waits; k++) begin
      i_mem_ready = (k == waits);
      i_mem_rdata = (k == waits) ? rd : $urandom;
      check({tag, ".mem_req"},  32'(or_mem_req), 1);
      check({tag, ".mem_addr"}, or_mem_addr, addr & ~32'h3);
      check({tag, ".mem_we"},   32'(or_mem_we), 0);
      check({tag, ".wstrb"},    32'(or_mem_wstrb), 0);
      check({tag, ".early_ack"}, 32'(or_inst_ack), 0);
      @(posedge i_clk); #1;
    end
    i_mem_ready = 0;
    check({tag, ".ack"},      32'(or_inst_ack), 1);
    check({tag, ".data"},     or_inst_data, rd);
    check({tag, ".data_ack"}, 32'(or_data_ack), 0);
    i_inst_req = 0;
    @(posedge i_clk); #1;
    check({tag, ".ack_pulse"}, 32'(or_inst_ack), 0);
    check({tag, ".idle"},      32'(or_busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"},    32'(or_mem_req), 0);
    check({tag, ".mem_addr"},   or_mem_addr, 0);
    check({tag, ".mem_we"},     32'(or_mem_we), 0);
    check({tag, ".wstrb"},      32'(or_mem_wstrb), 0);
    check({tag, ".wdata"},      or_mem_wdata, 0);
    check({tag, ".inst_ack"},   32'(or_inst_ack), 0);
    check({tag, ".inst_data"},  or_inst_data, 0);
    check({tag, ".data_ack"},   32'(or_data_ack), 0);
    check({tag, ".data_rdata"}, or_data_rdata, 0);
    check({tag, ".data_err"},   32'(or_data_err), 0);
    check({tag, ".busy"},       32'(or_busy), 0);
  endtask

  initial begin
    logic [31:0] obs;
    int acks;
    logic prev_ack;

    i_rst = 1'b1;
    #1 check_all_zero("reset");
    do_reset();

    // Directed cases.
    run_inst("fetch", 32'h0000_0104, 32'h0010_0093, 0);
    run_data("sb", 32'h2003, 1, 3'b000, 32'h0000_00A5, 0, 0, obs);
    run_data("sh", 32'h2002, 1, 3'b001, 32'h0000_1234, 0, 0, obs);
    run_data("lb", 32'h2001, 0, 3'b000, 0, 32'h0000_8000, 0, obs);
    check("lb.const", obs, 32'hFFFF_FF80);
    run_data("lbu", 32'h2001, 0, 3'b100, 0, 32'h0000_8000, 0, obs);
    check("lbu.const", obs, 32'h0000_0080);
    run_data("lh", 32'h2002, 0, 3'b001, 0, 32'hFFFE_0000, 0, obs);
    check("lh.const", obs, 32'hFFFF_FFFE);
    run_data("lw_mis", 32'h2002, 0, 3'b010, 0, 32'h1111_1111, 0, obs);
    run_data("lw_wait3", 32'h2004, 0, 3'b010, 0, 32'hCAFE_F00D, 3, obs);
    check("lw_wait3.const", obs, 32'hCAFE_F00D);
    run_data("sh_mis", 32'h2005, 1, 3'b101, 32'hFFFF, 0, 0, obs);
    run_data("sw_f3_111", 32'h2008, 1, 3'b111, 32'h89AB_CDEF, 0, 1, obs);

    // Contention: both held; after reset, order must be data, inst, data, inst.
    do_reset();
    i_inst_req = 1; i_inst_addr = 32'h40;
    i_data_req = 1; i_data_addr = 32'h80; i_data_we = 0; i_data_funct3 = 3'b010;
    acks = 0; prev_ack = 0;
    for (int c = 0; c < 80 && acks < 4; c++) begin
      @(posedge i_clk); #1;
      i_mem_ready = 1'($urandom_range(0, 1));
      i_mem_rdata = $urandom;
      if (or_inst_ack || or_data_ack) begin
        check("cont.onehot", 32'(or_inst_ack && or_data_ack), 0);
        check("cont.pulse", 32'(prev_ack), 0);
        check("cont.order", 32'(or_data_ack), (acks % 2 == 0) ? 1 : 0);
        acks++;
      end
      prev_ack = or_inst_ack || or_data_ack;
    end
    check("cont.count", acks, 4);
    i_inst_req = 0; i_data_req = 0; i_mem_ready = 0;
    repeat (4) @(posedge i_clk);
    #1;

    // Reset while a store waits on memory.
    i_data_req = 1; i_data_addr = 32'h3000; i_data_we = 1; i_data_funct3 = 3'b010;
    i_data_wdata = 32'hDEAD_BEEF;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    check("rst_mid.mem_req_before", 32'(or_mem_req), 1);
    i_rst = 1'b1;
    #1 check_all_zero("rst_mid");
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_data_req = 0;
    run_inst("after_rst", 32'h0000_0104, 32'h0010_0093, 0);

    // Randomized single-requester transactions.
    for (int t = 0; t < 60; t++) begin
      logic [31:0] a, wd, rd;
      logic [2:0]  f3;
      logic        we;
      int          w;
      a  = 32'h1000 + $urandom_range(0, 255);
      wd = $urandom; rd = $urandom;
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      w  = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) run_inst("rnd_inst", a, rd, w);
      else run_data(we ? "rnd_st" : "rnd_ld", a, we, f3, wd, rd, w, obs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter between the CPU core's instruction-fetch and data-access request interfaces and one shared memory port. Accepts level-held requests from both sides, grants one at a time, and drives a req/ready memory handshake. Formats store byte lanes and aligns and sign-extends load data per funct3. Returns a one-cycle acknowledge with data to the granted side. Sits directly below the core: consumes its inst/data request, address and read/write outputs, and produces its ack and received-data inputs.

## Interface
- XLEN, 32, data and address width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_inst_req  in  1  instruction fetch request, held until or_inst_ack
- i_inst_addr  in  XLEN  fetch byte address; bits [1:0] ignored
- or_inst_ack  out  1  one-cycle pulse: fetch done
- or_inst_data  out  XLEN  fetched word, valid while or_inst_ack=1
- i_data_req  in  1  load/store request, held until or_data_ack
- i_data_addr  in  XLEN  load/store byte address
- i_data_we  in  1  0=load, 1=store
- i_data_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_data_wdata  in  XLEN  store data, right-aligned
- or_data_ack  out  1  one-cycle pulse: load/store done
- or_data_rdata  out  XLEN  aligned, extended load result, valid with or_data_ack
- or_data_err  out  1  misaligned access; pulses together with or_data_ack
- or_mem_req  out  1  memory request, held until i_mem_ready
- or_mem_addr  out  XLEN  word address {addr[31:2],2'b00}
- or_mem_we  out  1  write enable
- or_mem_wstrb  out  4  byte-lane strobes; 0000 on reads
- or_mem_wdata  out  XLEN  lane-replicated store data
- i_mem_ready  in  1  memory completes the current request this cycle
- i_mem_rdata  in  XLEN  read word, valid when i_mem_ready=1
- or_busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, INST, DATA, ACK.
- IDLE, evaluated each edge:
  - Only one request pending: grant it.
  - Both pending: grant data, unless the previous grant was data, in which case grant inst. Alternates under contention; no starvation.
- Grant action: latch address, we, funct3 and wdata into registers. Enter INST or DATA with or_mem_req=1.
- Misaligned data request: no memory access; go straight to ACK with err set.
  - Half-word: addr[0]=1.
  - Word: addr[1:0]≠00.
- INST/DATA: hold or_mem_req and all or_mem_* stable until i_mem_ready=1. At that edge: capture i_mem_rdata, drop or_mem_req, enter ACK.
- ACK: pulse exactly one of or_inst_ack/or_data_ack for one cycle, with data (and err) valid, then go to IDLE.
  - The acknowledged side's request is not sampled until IDLE. The requester drops or re-raises it in the ACK cycle.
- Stores:
  - wstrb: B = 0001<<a[1:0]; H = 0011<<{a[1],0}; W = 1111.
  - wdata: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata.
- Loads:
  - Select the byte or half-word by a[1:0] or a[1].
  - Zero-extend for BU/HU; sign-extend for B/H.
  - or_data_rdata = 0 on err.
- Request dropped mid-transaction: the transaction completes and ack still pulses. The requester ignores it.
- funct3 011/110/111: treated as W.

## Timing
- Reset (async, immediate): state=IDLE, last-grant=inst. All outputs 0 (acks, err, or_mem_req, addr, wdata, wstrb, we, rdata/data, busy).
  - An in-flight memory request is abandoned: or_mem_req falls without waiting for ready.
- Latency, zero-wait memory:
  - Request seen high at edge 0.
  - or_mem_req high in cycle 1.
  - i_mem_ready=1 in cycle 1.
  - Ack in cycle 2.
- Each memory wait cycle adds one cycle.
- Misaligned access: ack/err in cycle 1.
- Minimum spacing between grants: 3 cycles (grant, mem, ACK).
- i_mem_ready while or_mem_req=0 is ignored.

## Test plan
- Fetch only, addr 0x0000_0104, ready immediate, rdata 0x0010_0093:
  - or_mem_addr=0x104, wstrb=0000.
  - or_inst_ack in cycle 2, or_inst_data=0x0010_0093.
- Simultaneous inst and data, both held continuously:
  - Grant order is data, inst, data, inst.
  - Each ack is a single-cycle pulse.
- SB 0xA5 to 0x2003: wstrb=1000, wdata=0xA5A5_A5A5, addr=0x2000.
- SH 0x1234 to 0x2002: wstrb=1100, wdata=0x1234_1234.
- LB at 0x2001, rdata 0x0000_8000: result 0xFFFF_FF80.
- LBU at the same address: result 0x0000_0080.
- LH at 0x2002, rdata 0xFFFE_0000: result 0xFFFF_FFFE.
- LW at 0x2002:
  - No or_mem_req.
  - or_data_ack and or_data_err in cycle 1, rdata 0.
- Ready delayed 3 cycles: or_mem_* stable throughout; ack in cycle 5.
- i_rst asserted mid-DATA wait:
  - All outputs 0 immediately.
  - After release, a new fetch completes normally.
